// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit user registers, written either directly or
// through shadow registers that are committed by a COMMIT write or by user_load.

module opb_rb_reg #(
  parameter int SHADOW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        commit,
  output logic [31:0] out_q,
  output logic [31:0] shadow_q,
  output logic        update
);
  // be[3] covers wdata[31:24] (the OPB's first byte lane)
  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (en[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      shadow_q <= '0;
      update   <= 1'b0;
    end else if (SHADOW != 0) begin
      // commit copies the pre-write shadow; a same-edge write lands in the shadow only
      update <= commit;
      if (commit) out_q <= shadow_q;
      if (wr_en) shadow_q <= merge(shadow_q, wdata, be);
    end else begin
      update <= wr_en;
      if (wr_en) out_q <= merge(out_q, wdata, be);
    end
  end
endmodule

module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01003600,
  parameter logic [31:0] C_HIGHADDR   = 32'h010036FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_SHADOW     = 0,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:31]                OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:31]                OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:31]                Sl_DBus,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic                       Sl_xferAck,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_update,
  input  logic                       user_load
);
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t state, state_next;

  // Big-endian bus vectors map onto [31:0] by position: bus bit k is user bit 31-k.
  logic [31:0] abus, off;
  logic        in_win, take;
  logic [29:0] widx_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;
  logic        rnw_q;
  logic        is_reg, is_commit, wr, commit;
  logic [31:0] rd_val;

  logic [C_NUM_REGS-1:0]           wr_en;
  logic [C_NUM_REGS-1:0][31:0]     out_q, sh_q;

  assign abus   = OPB_ABus;
  assign off    = abus - C_BASEADDR;
  assign in_win = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign take   = (state == IDLE) && OPB_select && in_win;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (OPB_select && in_win) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      widx_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      rnw_q  <= 1'b0;
    end else if (take) begin
      widx_q <= off[31:2];
      data_q <= OPB_DBus;
      be_q   <= OPB_BE;
      rnw_q  <= OPB_RNW;
    end
  end

  assign is_reg    = widx_q < 30'(C_NUM_REGS);
  assign is_commit = widx_q == 30'(C_NUM_REGS);
  assign wr        = (state == ACK) && !rnw_q;
  assign commit    = (C_SHADOW != 0) && (user_load || (wr && is_commit));

  for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
    assign wr_en[gi] = wr && (widx_q == 30'(gi));
    opb_rb_reg #(.SHADOW(C_SHADOW)) u_reg (
      .clk      (OPB_Clk),
      .rst      (OPB_Rst),
      .wr_en    (wr_en[gi]),
      .wdata    (data_q),
      .be       (be_q),
      .commit   (commit),
      .out_q    (out_q[gi]),
      .shadow_q (sh_q[gi]),
      .update   (user_update[gi])
    );
  end

  assign user_data_out = out_q;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++)
      if (widx_q == 30'(i)) rd_val = (C_SHADOW != 0) ? sh_q[i] : out_q[i];
  end

  always_comb begin
    Sl_xferAck = (state == ACK);
    Sl_DBus    = '0;
    if (state == ACK && rnw_q && is_reg) Sl_DBus = rd_val;
  end

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, off[1:0], (C_FAMILY == ""),
                       (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32)};
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Drives a direct-mode and a shadow-mode bank from one shared OPB and checks both
// against a directed vector table and a randomized run scored by an array model.
module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE = 32'h01003600;
  localparam logic [31:0] HIGH = 32'h010036FF;
  localparam int NR = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] abus = '0, dbus = '0;
  logic [3:0]  be = '0;
  logic        rnw = 1'b0, sel = 1'b0, seq = 1'b0, load = 1'b0;

  logic [31:0]      rd_d, rd_s;
  logic             err_d, retry_d, tout_d, ack_d, err_s, retry_s, tout_s, ack_s;
  logic [NR*32-1:0] udo_d, udo_s;
  logic [NR-1:0]    upd_d, upd_s;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(.C_NUM_REGS(NR), .C_SHADOW(0)) dut_d (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(rd_d),
    .Sl_errAck(err_d), .Sl_retry(retry_d), .Sl_toutSup(tout_d), .Sl_xferAck(ack_d),
    .user_data_out(udo_d), .user_update(upd_d), .user_load(load));

  opb_register_bank_ppc2simulink #(.C_NUM_REGS(NR), .C_SHADOW(1)) dut_s (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(rd_s),
    .Sl_errAck(err_s), .Sl_retry(retry_s), .Sl_toutSup(tout_s), .Sl_xferAck(ack_s),
    .user_data_out(udo_s), .user_update(upd_s), .user_load(load));

  // reference model: direct outputs, shadow-mode shadows and shadow-mode outputs
  logic [31:0]   m_d[NR], m_sh[NR], m_so[NR];
  logic [NR-1:0] e_upd_d, e_upd_s;
  int errors = 0, checks = 0;

  typedef struct {
    logic [31:0] addr; logic rnw; logic [31:0] data; logic [3:0] be; logic load;
    logic exp_ack; logic [31:0] exp_rd_d, exp_rd_s; logic [3:0] exp_upd_d, exp_upd_s;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bytewrite(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] en);
    logic [31:0] mask;
    mask = {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_d[i] = '0; m_sh[i] = '0; m_so[i] = '0; end
    e_upd_d = '0; e_upd_s = '0;
  endtask

  task automatic check_state(input string tag);
    logic [NR*32-1:0] ed, es;
    for (int i = 0; i < NR; i++) begin ed[32*i +: 32] = m_d[i]; es[32*i +: 32] = m_so[i]; end
    chk({tag, " udo_direct"}, udo_d, ed);
    chk({tag, " udo_shadow"}, udo_s, es);
    chk({tag, " upd_direct"}, upd_d, e_upd_d);
    chk({tag, " upd_shadow"}, upd_s, e_upd_s);
    chk({tag, " tied"}, {err_d, retry_d, tout_d, err_s, retry_s, tout_s}, 0);
  endtask

  // One beat starting at a negedge: select cycle, ACK cycle, then the cycle after.
  task automatic xfer(input logic [31:0] addr, input logic rnw_i, input logic [31:0] data,
                      input logic [3:0] be_i, input logic load_i,
                      output logic got_ack, output logic [31:0] got_d, output logic [31:0] got_s);
    logic hit, is_reg, is_com;
    int widx;
    logic [31:0] exp_d, exp_s;
    hit    = (addr >= BASE) && (addr <= HIGH);
    widx   = int'((addr - BASE) >> 2);
    is_reg = hit && widx < NR;
    is_com = hit && widx == NR;
    sel = 1'b1; abus = addr; dbus = data; be = be_i; rnw = rnw_i;
    @(negedge clk);
    // scramble the bus during ACK: effects must come from the captured request
    sel = 1'b0; abus = $urandom; dbus = $urandom; be = 4'($urandom); rnw = 1'($urandom);
    load = load_i;
    exp_d = '0; exp_s = '0;
    if (rnw_i && is_reg) begin exp_d = m_d[widx]; exp_s = m_sh[widx]; end
    chk("ack_direct", ack_d, hit);
    chk("ack_shadow", ack_s, hit);
    chk("rdata_direct", rd_d, exp_d);
    chk("rdata_shadow", rd_s, exp_s);
    got_ack = ack_d; got_d = rd_d; got_s = rd_s;
    e_upd_d = '0; e_upd_s = '0;
    if (hit && !rnw_i && is_reg) begin
      m_d[widx] = bytewrite(m_d[widx], data, be_i);
      e_upd_d[widx] = 1'b1;
    end
    if (load_i || (hit && !rnw_i && is_com)) begin
      for (int i = 0; i < NR; i++) m_so[i] = m_sh[i];
      e_upd_s = '1;
    end
    if (hit && !rnw_i && is_reg) m_sh[widx] = bytewrite(m_sh[widx], data, be_i);
    @(negedge clk);
    load = 1'b0;
    chk("ack_after", {ack_d, ack_s}, 2'b00);
    chk("rdata_idle", {rd_d, rd_s}, 64'd0);
    check_state("post");
  endtask

  initial begin
    logic a; logic [31:0] gd, gs, addr;
    model_reset();
    tbl[0]  = '{BASE+4,     0, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 4'b0010, 4'b0000};
    tbl[1]  = '{BASE+4,     1, 0,            4'hF, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    tbl[2]  = '{BASE+0,     0, 32'h11223344, 4'hF, 0, 1, 0, 0, 4'b0001, 0};
    tbl[3]  = '{BASE+0,     0, 32'hAABBCCDD, 4'b0100, 0, 1, 0, 0, 4'b0001, 0};
    tbl[4]  = '{BASE+0,     1, 0,            4'hF, 0, 1, 32'h11BB3344, 32'h11BB3344, 0, 0};
    tbl[5]  = '{BASE+8,     0, 32'h12345678, 4'hF, 0, 1, 0, 0, 4'b0100, 0};
    tbl[6]  = '{BASE+8,     1, 0,            4'hF, 0, 1, 32'h12345678, 32'h12345678, 0, 0};
    tbl[7]  = '{BASE+16,    0, $urandom,     4'($urandom), 0, 1, 0, 0, 0, 4'b1111};
    tbl[8]  = '{BASE+4,     0, 32'h9,        4'hF, 0, 1, 0, 0, 4'b0010, 0};
    tbl[9]  = '{BASE+4,     0, 32'h5,        4'hF, 1, 1, 0, 0, 4'b0010, 4'b1111};
    tbl[10] = '{BASE+4,     1, 0,            4'hF, 0, 1, 32'h5, 32'h5, 0, 0};
    tbl[11] = '{BASE+32'h40, 1, 0,           4'hF, 0, 1, 0, 0, 0, 0};
    tbl[12] = '{BASE+32'h40, 0, 32'hFFFFFFFF, 4'hF, 0, 1, 0, 0, 0, 0};
    tbl[13] = '{HIGH+4,     0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{BASE+16,    1, 0,            4'hF, 0, 1, 0, 0, 0, 0};
    tbl[15] = '{BASE-4,     1, 0,            4'hF, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{BASE+32'hE, 0, 32'hA5A5A5A5, 4'hF, 0, 1, 0, 0, 4'b1000, 0};
    tbl[17] = '{BASE+32'hF, 1, 0,            4'hF, 0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset ack", {ack_d, ack_s}, 2'b00);
    chk("reset rdata", {rd_d, rd_s}, 64'd0);
    check_state("reset");

    for (int i = 0; i < 18; i++) begin
      xfer(tbl[i].addr, tbl[i].rnw, tbl[i].data, tbl[i].be, tbl[i].load, a, gd, gs);
      chk($sformatf("vec%0d ack", i), a, tbl[i].exp_ack);
      chk($sformatf("vec%0d rd_direct", i), gd, tbl[i].exp_rd_d);
      chk($sformatf("vec%0d rd_shadow", i), gs, tbl[i].exp_rd_s);
      chk($sformatf("vec%0d upd_direct", i), upd_d, tbl[i].exp_upd_d);
      chk($sformatf("vec%0d upd_shadow", i), upd_s, tbl[i].exp_upd_s);
    end
    chk("commit slice1", udo_s[63:32], 32'h9);
    chk("commit slice2", udo_s[95:64], 32'h12345678);

    // user_load held for three cycles commits every cycle
    xfer(BASE+12, 1'b0, $urandom, 4'hF, 1'b0, a, gd, gs);
    load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) m_so[i] = m_sh[i];
      e_upd_d = '0; e_upd_s = '1;
      check_state($sformatf("load%0d", k));
    end
    load = 1'b0;
    @(negedge clk);
    e_upd_s = '0;
    check_state("load_end");

    // reset in the ACK cycle of a write aborts it; select/load ignored during reset
    sel = 1'b1; abus = BASE; rnw = 1'b0; dbus = 32'hCAFEF00D; be = 4'hF;
    @(negedge clk);
    sel = 1'b0; rst = 1'b1; load = 1'b1;
    chk("rst_in_ack ack", ack_d, 1'b1);
    @(negedge clk);
    model_reset();
    sel = 1'b1; abus = BASE+4;
    chk("rst ack", {ack_d, ack_s}, 2'b00);
    check_state("rst");
    @(negedge clk);
    rst = 1'b0; sel = 1'b0; load = 1'b0;
    chk("rst_sel_ignored", {ack_d, ack_s}, 2'b00);
    check_state("rst_rel");
    xfer(BASE, 1'b1, 0, 4'hF, 1'b0, a, gd, gs);

    // randomized traffic scored by the model
    for (int n = 0; n < 100; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: addr = BASE + 32'($urandom_range(0, NR-1)) * 4 + 32'($urandom_range(0, 3));
        3:       addr = BASE + 4*NR;
        4:       addr = BASE + 4 * 32'($urandom_range(NR+1, 63));
        5:       addr = HIGH + 4;
        default: addr = BASE - 4;
      endcase
      seq = 1'($urandom);
      xfer(addr, 1'($urandom), $urandom, 4'($urandom), ($urandom_range(0, 3) == 0), a, gd, gs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/opb_register_bank_ppc2simulink.md
OPB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: opb_register_bank_ppc2simulink

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01003600, meaning bank base address.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010036FF, meaning bank high address; the decode window is C_BASEADDR..C_HIGHADDR inclusive.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, and C_OPB_DWIDTH, default 32, meaning bus widths; only 32/32 is supported.
REQ-004 SHALL have parameter C_NUM_REGS, default 4, range 1..16, meaning the number of 32-bit registers.
REQ-005 SHALL have parameter C_SHADOW, default 0, meaning 0 = direct-write mode and 1 = shadow/commit mode.
REQ-006 SHALL have parameter C_FAMILY, default "virtex5", meaning informational only.
REQ-007 Ports, in order:
- OPB_Clk  in  1  sole clock; all logic is on its rising edge.
- OPB_Rst  in  1  reset, synchronous, active-high.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
- OPB_DBus  in  [0:31]  write data; bit 0 is the MSB.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- user_data_out  out  [C_NUM_REGS*32-1:0]  register i occupies bits [32*i+31:32*i].
- user_update  out  [C_NUM_REGS-1:0]  per-register one-cycle update pulse.
- user_load  in  1  commit request (shadow mode only; ignored when C_SHADOW=0).

Function
REQ-008 Address map (offsets from C_BASEADDR):
- Register i is at offset 4*i.
- The COMMIT location is at offset 4*C_NUM_REGS.
- Any other in-window address is a "null" address.
- ABus[30:31] is ignored.
REQ-009 Bit mapping: OPB_DBus[k] SHALL correspond to user bit 31-k, both for writes and for readback on Sl_DBus.
REQ-010 The state machine SHALL have two states, IDLE and ACK:
- IDLE -> ACK when OPB_select=1 and the address is in the window.
- ACK -> IDLE unconditionally.
REQ-011 Sl_xferAck SHALL be 1 exactly in the ACK cycle, giving a fixed 1-cycle latency from select to ack.
REQ-012 A back-to-back transfer SHALL be accepted starting in the cycle after ACK, so each beat takes 2 cycles.
REQ-013 Out-of-window selects SHALL receive no ack and SHALL have no effect.
REQ-014 Address, data, BE and RNW SHALL be registered on the IDLE->ACK edge; all effects use these registered values.
REQ-015 Sl_DBus SHALL be 0 in every cycle except ACK-with-read.
REQ-016 In ACK-with-read, Sl_DBus SHALL return the register value: the output value if C_SHADOW=0, or the shadow value if C_SHADOW=1. COMMIT and null addresses SHALL read 0.
REQ-017 A write SHALL take effect on the clock edge that ends the ACK cycle, updating only the bytes whose BE bit is 1.
REQ-018 Direct mode: a register write SHALL update user_data_out slice i.
REQ-019 Direct mode: user_update[i] SHALL pulse for one cycle, on the cycle after ACK, for any write to register i, including a write with BE=0000.
REQ-020 Shadow mode: a register write SHALL update shadow i only; user_data_out SHALL be unchanged.
REQ-021 Shadow mode: a write to COMMIT (any data, any BE) or user_load=1 SHALL copy every shadow into user_data_out, and every user_update bit SHALL pulse for one cycle after the commit edge.
REQ-022 Simultaneous register write and user_load: the commit SHALL copy the pre-write shadow, and the write SHALL land in the shadow only.
REQ-023 Null-address writes and direct-mode COMMIT writes SHALL be acked and discarded, with no user_update pulse.
REQ-024 user_load held high for N cycles SHALL commit on every one of those cycles, pulsing user_update each cycle.

Reset
REQ-025 OPB_Rst=1 at a rising edge SHALL force: state IDLE; user_data_out, all shadows, user_update, Sl_DBus and Sl_xferAck all 0.
REQ-026 Reset asserted in the ACK cycle SHALL abort the transfer: no write takes effect, and Sl_xferAck=0 on the following cycle.
REQ-027 OPB_select and user_load SHALL be ignored while OPB_Rst=1.

Verification
REQ-028 Direct mode, write 0xDEADBEEF with BE=1111 to offset 0x4 -> ack 1 cycle after select; user_data_out[63:32]=0xDEADBEEF and user_update=0010 one cycle after ack; readback at 0x4 = 0xDEADBEEF.
REQ-029 Partial write: from reg0=0x11223344, write 0xAABBCCDD with BE=0100 -> reg0=0x11BB3344.
REQ-030 Shadow mode, write 0x12345678 to reg2 -> output stays 0 and readback = 0x12345678; then write COMMIT -> output slice 2 = 0x12345678 and user_update=1111 for one cycle.
REQ-031 Shadow mode: user_load and a write of 0x5 to reg1 (shadow 0x9) in the same edge -> output slice 1 = 0x9, shadow = 0x5.
REQ-032 Select with address C_HIGHADDR+4 -> no ack and no state change; select with a null address -> ack, read 0, no effect.
REQ-033 Assert OPB_Rst in the ACK cycle of a write -> register unchanged; all outputs 0 after reset.
